// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared state encoding and constants for the instruction fetch unit
// Revision : 1.0
// ============================================================================
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        DONE    = 2'b10,
        DISCARD = 2'b11
    } ifu_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Single-outstanding fetch FSM between PC register and instr memory
// Revision : 1.0
// ============================================================================
module instruction_fetch_unit
    import ifu_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    input  logic        Flush,
    input  logic        DecodeStall,
    input  logic        MemReady,
    input  logic [31:0] MemData,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic        Stall,
    output logic        AlignErr,
    output logic [31:0] FetchCount
);

    ifu_state_t state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            MemReq      <= 1'b0;
            MemAddr     <= 32'h0000_0000;
            Instruction <= NOP_WORD;
            InstrValid  <= 1'b0;
            AlignErr    <= 1'b0;
            FetchCount  <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    state   <= WAIT;
                    MemReq  <= 1'b1;
                    MemAddr <= {PCResult[31:2], 2'b00};
                    if (PCResult[1:0] != 2'b00) begin
                        AlignErr <= 1'b1;
                    end
                end
                WAIT: begin
                    if (Flush) begin
                        // A flushed request still owes the memory its response
                        if (MemReady) begin
                            state  <= IDLE;
                            MemReq <= 1'b0;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (MemReady) begin
                        state       <= DONE;
                        Instruction <= MemData;
                        InstrValid  <= 1'b1;
                        MemReq      <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (MemReady) begin
                        state  <= IDLE;
                        MemReq <= 1'b0;
                    end
                end
                DONE: begin
                    if (Flush || !DecodeStall) begin
                        state      <= IDLE;
                        InstrValid <= 1'b0;
                        if (!Flush) begin
                            FetchCount <= FetchCount + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Stall = ~((state == DONE) & (~DecodeStall | Flush));

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset, ports Clk and Reset; all state SHALL update on posedge Clk.
REQ-002 Clk  input  1  system clock.
REQ-003 Reset  input  1  asynchronous active-high reset.
REQ-004 PCResult  input  32  current PC register value (fetch address).
REQ-005 Flush  input  1  kill in-flight or held fetch (branch/jump taken).
REQ-006 DecodeStall  input  1  decode stage cannot accept an instruction this cycle.
REQ-007 MemReady  input  1  instruction memory returns MemData this cycle.
REQ-008 MemData  input  32  instruction word from memory.
REQ-009 MemReq  output  1  registered request to instruction memory.
REQ-010 MemAddr  output  32  registered word-aligned request address.
REQ-011 Instruction  output  32  registered fetched instruction to IF/ID.
REQ-012 InstrValid  output  1  Instruction holds a valid, unconsumed word.
REQ-013 Stall  output  1  combinational hold to the PC register (1 = PC keeps value).
REQ-014 AlignErr  output  1  sticky flag: misaligned PC seen at request issue.
REQ-015 FetchCount  output  32  count of instructions handed to decode.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DONE, DISCARD.
REQ-017 IDLE: next edge -> WAIT, MemReq<=1, MemAddr<={PCResult[31:2],2'b00}; AlignErr<=1 if PCResult[1:0]!=0.
REQ-018 WAIT: MemReq and MemAddr held stable until MemReady=1.
REQ-019 WAIT with MemReady=1, Flush=0 -> DONE, Instruction<=MemData, InstrValid<=1, MemReq<=0.
REQ-020 WAIT with Flush=1 (any MemReady) -> DISCARD if MemReady=0, else IDLE; returned data dropped, InstrValid stays 0.
REQ-021 DISCARD: MemReq held until MemReady=1, data dropped, then -> IDLE with MemReq<=0.
REQ-022 DONE with DecodeStall=0 or Flush=1 -> IDLE, InstrValid<=0; FetchCount+=1 only when Flush=0 and DecodeStall=0.
REQ-023 DONE with DecodeStall=1, Flush=0: remain, Instruction and InstrValid held.
REQ-024 Stall SHALL be 0 only in DONE with (DecodeStall=0 or Flush=1); 1 in all other states.
REQ-025 Flush in IDLE SHALL have no effect.
REQ-026 Minimum latency: request issue 1 cycle after IDLE entry; memory-ready-same-cycle gives 3 cycles per instruction (IDLE, WAIT, DONE).
REQ-027 FetchCount SHALL wrap 0xFFFFFFFF -> 0x00000000 without flag.
REQ-028 AlignErr SHALL remain set until Reset.

Reset
REQ-029 Reset SHALL force, asynchronously: state IDLE, MemReq=0, MemAddr=0, Instruction=0, InstrValid=0, AlignErr=0, FetchCount=0; Stall therefore 1.
REQ-030 Reset asserted mid-fetch SHALL abandon the request; a MemReady arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-031 State encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10, DISCARD=2'b11) and NOP word 32'h0 SHALL live in shared package ifu_pkg.
REQ-032 No sub-module; FetchCount SHALL be a plain register in this module; PC register stays external, driven by Stall.

Verification
REQ-033 Reset, PCResult=0x00000000, MemReady=1 in first WAIT cycle, MemData=0x20080005 -> Instruction=0x20080005, InstrValid=1, Stall=0 for one cycle, FetchCount=1.
REQ-034 MemReady held 0 for 4 WAIT cycles, PCResult=0x00000010 -> MemReq=1, MemAddr=0x00000010 stable, Stall=1 throughout; completes on 5th cycle.
REQ-035 DONE with DecodeStall=1 for 3 cycles -> Instruction unchanged, Stall=1, FetchCount unchanged; DecodeStall=0 -> single Stall=0 cycle, FetchCount+1.
REQ-036 Flush in WAIT with MemReady=0, then MemReady=1 two cycles later with 0xDEADBEEF -> DISCARD entered, InstrValid never 1, FetchCount unchanged, then IDLE.
REQ-037 PCResult=0x00000006 at issue -> MemAddr=0x00000004, AlignErr=1 persisting across later fetches until Reset.
REQ-038 FetchCount preloaded via 2^32-1 completions (or forced) then one completion -> FetchCount=0; Reset asserted in WAIT -> all outputs at reset values within same cycle.
